// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone types, defaults and arbiter state encoding
//
// Purpose : common definitions for the two-master Wishbone arbiter slice.
// Contents: default address/data widths, request/response bundles,
//           arbiter state enum and a state-to-owner decode helper.
package wb_pkg;

  localparam int WB_AW = 30;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef struct packed {
    logic             cyc;
    logic             stb;
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

  typedef struct packed {
    logic             stall;
    logic             ack;
    logic             err;
    logic [WB_DW-1:0] data;
  } wb_rsp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  // One-hot owner as seen by the top level; ABORT reports no owner.
  function automatic logic [1:0] owner_onehot(input arb_state_t s);
    logic [1:0] r;
    r = 2'b00;
    if (s == OWN0) r = 2'b01;
    if (s == OWN1) r = 2'b10;
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - bus-cycle watchdog for the Wishbone arbiter
//
// Purpose : counts consecutive owned clocks with the slave cycle open and no
//           ack/err; raises o_fire for one clock once the limit is reached.
// Ports   : i_clk, i_reset_n (async active-low)
//           i_active   - an owner holds the slave cycle this clock
//           i_progress - slave answered (ack or err) this clock
//           o_fire     - timeout, asserted in the clock after the limit count
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_active,
  input  logic i_progress,
  output logic o_fire
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  // Fire is combinational on the registered count; the arbiter leaves OWNx
  // on that same edge, so i_active drops and the pulse is one clock wide.
  assign o_fire = i_active && (cnt == LIMIT);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (!i_active || i_progress || o_fire) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master to one-slave pipelined Wishbone arbiter
//
// Purpose : round-robin grant, locked for the whole bus cycle (CYC high).
//           Arbitration is registered; the datapath mux is combinational on
//           the registered grant.
// Ports   : i_clk, i_reset_n (async active-low)
//           i_m0_* / o_m0_* - master 0 request in, response out
//           i_m1_* / o_m1_* - master 1 request in, response out
//           o_s_*  / i_s_*  - slave request out, response in
//           o_owner         - one-hot grant: 01 = m0, 10 = m1, 00 = none
// Option  : WB_ARB_TIMEOUT_EN enables the watchdog and the ABORT state.
module wb_arbiter_2m
  import wb_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic            i_clk,
  input  logic            i_reset_n,

  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_stall,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_data,

  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_stall,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_data,

  output logic            o_s_cyc,
  output logic            o_s_stb,
  output logic            o_s_we,
  output logic [AW-1:0]   o_s_addr,
  output logic [DW-1:0]   o_s_data,
  output logic [DW/8-1:0] o_s_sel,
  input  logic            i_s_stall,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  input  logic [DW-1:0]   i_s_data,

  output logic [1:0]      o_owner
);

  arb_state_t state, state_nxt;
  // 1 = master 1 was granted last, so master 0 wins the next tie.
  logic       last_m1, last_m1_nxt;
  logic       wd_fire;

`ifdef WB_ARB_TIMEOUT_EN
  logic wd_active;

  assign wd_active = ((state == OWN0) && i_m0_cyc) || ((state == OWN1) && i_m1_cyc);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_active   (wd_active),
    .i_progress (i_s_ack | i_s_err),
    .o_fire     (wd_fire)
  );
`else
  logic unused_timeout;

  assign wd_fire        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= IDLE;
      last_m1 <= 1'b1;
    end else begin
      state   <= state_nxt;
      last_m1 <= last_m1_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    last_m1_nxt = last_m1;
    case (state)
      IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last_m1)) begin
          state_nxt   = OWN0;
          last_m1_nxt = 1'b0;
        end else if (i_m1_cyc) begin
          state_nxt   = OWN1;
          last_m1_nxt = 1'b1;
        end
      end
      OWN0: begin
        if (wd_fire)        state_nxt = ABORT;
        else if (!i_m0_cyc) state_nxt = IDLE;
      end
      OWN1: begin
        if (wd_fire)        state_nxt = ABORT;
        else if (!i_m1_cyc) state_nxt = IDLE;
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        // last_m1 still names the master that was aborted.
        if (last_m1 ? !i_m1_cyc : !i_m0_cyc) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath mux. Responses are gated by the owner's cyc so that acks
  // arriving after the master released the cycle are dropped.
  always_comb begin
    o_owner    = owner_onehot(state);
    o_s_cyc    = 1'b0;
    o_s_stb    = 1'b0;
    o_s_we     = 1'b0;
    o_s_addr   = '0;
    o_s_data   = '0;
    o_s_sel    = '0;
    o_m0_stall = 1'b1;
    o_m0_ack   = 1'b0;
    o_m0_err   = 1'b0;
    o_m0_data  = '0;
    o_m1_stall = 1'b1;
    o_m1_ack   = 1'b0;
    o_m1_err   = 1'b0;
    o_m1_data  = '0;
    case (state)
      OWN0: begin
        o_s_cyc    = i_m0_cyc & ~wd_fire;
        o_s_stb    = i_m0_cyc & i_m0_stb & ~wd_fire;
        o_s_we     = i_m0_we;
        o_s_addr   = i_m0_addr;
        o_s_data   = i_m0_data;
        o_s_sel    = i_m0_sel;
        o_m0_stall = i_s_stall | wd_fire;
        o_m0_ack   = i_m0_cyc & i_s_ack & ~wd_fire;
        o_m0_err   = i_m0_cyc & (i_s_err | wd_fire);
        o_m0_data  = i_m0_cyc ? i_s_data : '0;
      end
      OWN1: begin
        o_s_cyc    = i_m1_cyc & ~wd_fire;
        o_s_stb    = i_m1_cyc & i_m1_stb & ~wd_fire;
        o_s_we     = i_m1_we;
        o_s_addr   = i_m1_addr;
        o_s_data   = i_m1_data;
        o_s_sel    = i_m1_sel;
        o_m1_stall = i_s_stall | wd_fire;
        o_m1_ack   = i_m1_cyc & i_s_ack & ~wd_fire;
        o_m1_err   = i_m1_cyc & (i_s_err | wd_fire);
        o_m1_data  = i_m1_cyc ? i_s_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - self-checking bench for wb_arbiter_2m
module tb_wb_arbiter_2m;

  typedef struct packed {
    logic        m0_cyc, m0_stb, m0_we;
    logic [29:0] m0_addr;
    logic [31:0] m0_data;
    logic        m1_cyc, m1_stb, m1_we;
    logic [29:0] m1_addr;
    logic [31:0] m1_data;
    logic        s_stall, s_ack;
    logic [31:0] s_data;
  } ins_t;

  typedef struct packed {
    logic [1:0]  owner;
    logic        s_cyc, s_stb, s_we;
    logic [29:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_sel;
    logic        m0_stall, m0_ack, m0_err;
    logic [31:0] m0_data;
    logic        m1_stall, m1_ack, m1_err;
    logic [31:0] m1_data;
  } outs_t;

  typedef struct packed {
    ins_t  in;
    outs_t exp;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_m0_cyc, i_m0_stb, i_m0_we, i_m1_cyc, i_m1_stb, i_m1_we;
  logic [29:0] i_m0_addr, i_m1_addr, o_s_addr;
  logic [31:0] i_m0_data, i_m1_data, o_m0_data, o_m1_data, o_s_data, i_s_data;
  logic [3:0]  i_m0_sel, i_m1_sel, o_s_sel;
  logic        o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err;
  logic        o_s_cyc, o_s_stb, o_s_we, i_s_stall, i_s_ack, i_s_err;
  logic [1:0]  o_owner;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 i_clk = ~i_clk;

  wb_arbiter_2m #(.AW(30), .DW(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_err(i_s_err), .i_s_data(i_s_data),
    .o_owner(o_owner)
  );

  function automatic ins_t mi(input bit c0, s0, w0, input logic [29:0] a0, input logic [31:0] d0,
                              input bit c1, s1, w1, input logic [29:0] a1, input logic [31:0] d1,
                              input bit st, ak, input logic [31:0] sd);
    ins_t r;
    r = '{c0, s0, w0, a0, d0, c1, s1, w1, a1, d1, st, ak, sd};
    return r;
  endfunction

  function automatic outs_t mo(input logic [1:0] ow, input bit cyc, stb, we,
                               input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl,
                               input bit st0, ak0, input logic [31:0] rd0,
                               input bit st1, ak1, input logic [31:0] rd1);
    outs_t r;
    r = '{ow, cyc, stb, we, a, d, sl, st0, ak0, 1'b0, rd0, st1, ak1, 1'b0, rd1};
    return r;
  endfunction

  function automatic outs_t cur();
    outs_t r;
    r = '{o_owner, o_s_cyc, o_s_stb, o_s_we, o_s_addr, o_s_data, o_s_sel,
          o_m0_stall, o_m0_ack, o_m0_err, o_m0_data, o_m1_stall, o_m1_ack, o_m1_err, o_m1_data};
    return r;
  endfunction

  task automatic drive(input ins_t x);
    i_m0_cyc = x.m0_cyc; i_m0_stb = x.m0_stb; i_m0_we = x.m0_we;
    i_m0_addr = x.m0_addr; i_m0_data = x.m0_data;
    i_m1_cyc = x.m1_cyc; i_m1_stb = x.m1_stb; i_m1_we = x.m1_we;
    i_m1_addr = x.m1_addr; i_m1_data = x.m1_data;
    i_s_stall = x.s_stall; i_s_ack = x.s_ack; i_s_data = x.s_data;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  vec_t vt[14];
  outs_t rst_o;
  ins_t  x;

  initial begin
    i_m0_sel = 4'hF;
    i_m1_sel = 4'h3;
    i_s_err  = 1'b0;
    x = '0;
    drive(x);
    rst_o = mo(2'b00, 0, 0, 0, 30'h0, 32'h0, 4'h0, 1, 0, 32'h0, 1, 0, 32'h0);

    vt[0]  = '{mi(0,0,0,30'h00,32'h00, 0,0,0,30'h00,32'h00, 0,0,32'h0), rst_o};
    vt[1]  = '{mi(1,1,1,30'h10,32'hA5, 0,0,0,30'h00,32'h00, 0,0,32'h0), rst_o};
    vt[2]  = '{mi(1,1,1,30'h10,32'hA5, 0,0,0,30'h00,32'h00, 0,0,32'h0),
               mo(2'b01, 1,1,1, 30'h10, 32'hA5, 4'hF, 0,0,32'h0, 1,0,32'h0)};
    vt[3]  = '{mi(1,0,1,30'h10,32'hA5, 0,0,0,30'h00,32'h00, 0,1,32'h0),
               mo(2'b01, 1,0,1, 30'h10, 32'hA5, 4'hF, 0,1,32'h0, 1,0,32'h0)};
    vt[4]  = '{mi(0,0,0,30'h00,32'h00, 1,1,0,30'h20,32'h5A, 0,0,32'h0),
               mo(2'b01, 0,0,0, 30'h00, 32'h00, 4'hF, 0,0,32'h0, 1,0,32'h0)};
    vt[5]  = '{mi(0,0,0,30'h00,32'h00, 1,1,0,30'h20,32'h5A, 0,0,32'h0), rst_o};
    vt[6]  = '{mi(0,0,0,30'h00,32'h00, 1,1,0,30'h20,32'h5A, 1,0,32'h0),
               mo(2'b10, 1,1,0, 30'h20, 32'h5A, 4'h3, 1,0,32'h0, 1,0,32'h0)};
    vt[7]  = vt[6];
    vt[8]  = vt[6];
    vt[9]  = '{mi(0,0,0,30'h00,32'h00, 1,1,0,30'h20,32'h5A, 0,0,32'h0),
               mo(2'b10, 1,1,0, 30'h20, 32'h5A, 4'h3, 1,0,32'h0, 0,0,32'h0)};
    vt[10] = '{mi(0,0,0,30'h00,32'h00, 1,0,0,30'h20,32'h5A, 0,1,32'hDEAD),
               mo(2'b10, 1,0,0, 30'h20, 32'h5A, 4'h3, 1,0,32'h0, 0,1,32'hDEAD)};
    vt[11] = '{mi(1,1,1,30'h10,32'hA5, 0,0,0,30'h00,32'h00, 0,1,32'hBEEF),
               mo(2'b10, 0,0,0, 30'h00, 32'h00, 4'h3, 1,0,32'h0, 0,0,32'h0)};
    vt[12] = '{mi(1,1,1,30'h10,32'hA5, 0,0,0,30'h00,32'h00, 0,0,32'h0), rst_o};
    vt[13] = '{mi(1,1,1,30'h10,32'hA5, 0,0,0,30'h00,32'h00, 0,0,32'h0),
               mo(2'b01, 1,1,1, 30'h10, 32'hA5, 4'hF, 0,0,32'h0, 1,0,32'h0)};

    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].in);
      #3;
      n_vec++;
      if (cur() !== vt[i].exp) begin
        n_miss++;
        $display("FAIL vec%0d: got %h expected %h", i, cur(), vt[i].exp);
      end
      tick();
    end

    // Asynchronous reset while m0 owns the bus.
    i_reset_n = 1'b0;
    #1;
    chk("rst_async_cyc", 64'(o_s_cyc), 64'd0);
    chk("rst_async_owner", 64'(o_owner), 64'd0);
    chk("rst_async_stall", 64'(o_m0_stall), 64'd1);
    x = '0;
    drive(x);
    tick();
    i_reset_n = 1'b1;
    x.m1_cyc = 1; x.m1_stb = 1; x.m1_addr = 30'h33;
    drive(x);
    #2 chk("rst_m1_wait", 64'(o_owner), 64'd0);
    tick();
    chk("rst_m1_grant", 64'(o_owner), 64'd2);
    chk("rst_m1_addr", 64'(o_s_addr), 64'h33);

    // Tie after reset, then round-robin handover.
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    x = '0;
    x.m0_cyc = 1; x.m0_stb = 1; x.m1_cyc = 1; x.m1_stb = 1;
    drive(x);
    #1 chk("tie_idle", 64'(o_owner), 64'd0);
    tick();
    chk("tie_m0", 64'(o_owner), 64'd1);
    x.m0_cyc = 0; x.m0_stb = 0;
    drive(x);
    tick();
    chk("handover_idle", 64'({o_owner, o_s_cyc}), 64'd0);
    tick();
    chk("handover_m1", 64'(o_owner), 64'd2);
    x.m1_cyc = 0; x.m1_stb = 0;
    drive(x);
    tick();
    x.m0_cyc = 1; x.m0_stb = 1; x.m1_cyc = 1; x.m1_stb = 1;
    drive(x);
    #1 chk("rr_idle", 64'(o_owner), 64'd0);
    tick();
    chk("rr_m0", 64'(o_owner), 64'd1);

    // Four pipelined reads by m0; data 1..4 returns one clock behind.
    x.m1_cyc = 0; x.m1_stb = 0;
    for (int k = 0; k < 5; k++) begin
      x.m0_stb  = (k < 4);
      x.m0_addr = 30'(k);
      x.s_ack   = (k >= 1);
      x.s_data  = 32'(k);
      drive(x);
      #2;
      chk($sformatf("rd%0d_stb_addr", k), 64'({o_s_stb, o_s_addr}), 64'({(k < 4), 30'(k)}));
      chk($sformatf("rd%0d_m0", k), 64'({o_m0_ack, o_m0_data}), 64'({(k >= 1), (k >= 1) ? 32'(k) : 32'h0}));
      chk($sformatf("rd%0d_m1", k), 64'({o_m1_ack, o_m1_data}), 64'd0);
      tick();
    end
    x = '0;
    drive(x);
    tick();

`ifdef WB_ARB_TIMEOUT_EN
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    x = '0;
    x.m0_cyc = 1; x.m0_stb = 1;
    drive(x);
    tick();
    for (int k = 1; k <= 10; k++) begin
      #2;
      chk($sformatf("to%0d_err", k), 64'(o_m0_err), 64'(k == 9));
      chk($sformatf("to%0d_cyc", k), 64'(o_s_cyc), 64'(k < 9));
      tick();
    end
    x.m0_cyc = 0; x.m0_stb = 0; x.m1_cyc = 1; x.m1_stb = 1;
    drive(x);
    tick();
    tick();
    chk("to_m1_grant", 64'(o_owner), 64'd2);
    x = '0;
    drive(x);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
Two-master to one-slave Wishbone (pipelined, B4) arbiter.
- Lets the UART-bridge master and a second master (local button/LED controller, future CPU) share the slave bus.
- Round-robin grant, locked for the whole bus cycle (CYC high).
- Sits between the masters and the slave in the top level. All arbitration is registered; the datapath mux is combinational on the registered grant.

Parameters:
AW, 30, address width (word address)
DW, 32, data width; select width is DW/8
TIMEOUT_CYCLES, 1023, watchdog limit in clocks (used only with WB_ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous, active-low reset
i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 request controls
i_m0_addr  in  AW  master 0 address
i_m0_data  in  DW  master 0 write data
i_m0_sel  in  DW/8  master 0 byte select
o_m0_stall, o_m0_ack, o_m0_err  out  1 each  master 0 responses
o_m0_data  out  DW  master 0 read data
i_m1_* / o_m1_*  same set as master 0, for master 1
o_s_cyc, o_s_stb, o_s_we  out  1 each  slave controls
o_s_addr  out  AW  slave address
o_s_data  out  DW  slave write data
o_s_sel  out  DW/8  slave byte select
i_s_stall, i_s_ack, i_s_err  in  1 each  slave responses
i_s_data  in  DW  slave read data
o_owner  out  2  one-hot current grant: 01 = m0, 10 = m1, 00 = none

Behaviour:
- Reset (async assert, sync release): state IDLE, o_owner=00, last_served=m1 so that m0 wins the first tie. All o_s_* are 0. o_mX_stall=1 for both masters. ack, err and data outputs are 0.
- States: IDLE, OWN0, OWN1 (plus ABORT, only with the macro).
- IDLE, next cycle:
  - only m0 cyc high -> OWN0; only m1 cyc high -> OWN1.
  - both high -> grant the master that is not last_served.
  - update last_served on every grant.
- OWNx:
  - o_s_cyc = i_mx_cyc; o_s_stb/we/addr/data/sel = master x signals.
  - o_mx_stall = i_s_stall; o_mx_ack = i_s_ack; o_mx_err = i_s_err; o_mx_data = i_s_data.
  - The other master sees stall=1, ack=0, err=0, data=0.
- Leaving OWNx: when i_mx_cyc=0 -> IDLE, taking one cycle.
  - Back-to-back handover therefore costs exactly one idle clock with o_s_cyc=0.
  - A new request from the same master in that IDLE cycle is granted only if the other master is not requesting.
- Grant latency: a request first seen in IDLE gets the slave one clock later. The requester sees stall=1 in the first cycle, so no stb is lost.
- No preemption: a master holding cyc keeps the bus indefinitely. Fairness relies on masters dropping cyc between transactions.
- Abort: a master dropping cyc with requests still outstanding aborts the slave cycle (o_s_cyc falls the same cycle). Late slave acks after release are not routed to either master.
- o_s_stb is never high while o_s_cyc is low.
- Reset mid-transfer: all outputs go to their reset values immediately (async); the slave sees cyc drop.

Optional Feature:
WB_ARB_TIMEOUT_EN.
- Defined:
  - a counter counts consecutive OWNx clocks with o_s_cyc=1 and neither i_s_ack nor i_s_err; it clears on ack/err and on leaving OWNx.
  - On reaching TIMEOUT_CYCLES: o_mx_err pulses high for exactly one clock, o_s_cyc/o_s_stb forced 0, and the state becomes ABORT.
  - ABORT: owner sees stall=1, ack=0; stays until i_mx_cyc=0, then IDLE.
- Not defined: no counter, no ABORT state; a hung slave hangs the bus.

Decomposition:
- Package wb_pkg:
  - AW/DW defaults
  - wb_req_t struct (cyc, stb, we, addr, data, sel)
  - wb_rsp_t struct (stall, ack, err, data)
  - arb_state_t enum (IDLE, OWN0, OWN1, ABORT)
- One natural sub-module: wb_arb_watchdog (counter, compare, err pulse). It is instantiated only under WB_ARB_TIMEOUT_EN.

Test Plan:
- Reset released, m0 cyc+stb write addr 0x10 data 0xA5 -> o_owner=01 one clock later; o_s_addr=0x10, o_s_data=0xA5; slave ack reaches o_m0_ack only; o_m1_ack stays 0.
- m0 and m1 both raise cyc in the same clock after reset -> m0 granted. m0 drops cyc -> one IDLE clock, then o_owner=10. Both re-request -> m0 granted (round-robin).
- m1 owns the bus, slave holds i_s_stall=1 for 3 clocks -> o_m1_stall=1 for those 3 clocks, o_m0_stall=1 throughout, and stb is presented to the slave until accepted.
- m0 issues 4 pipelined reads; slave returns data 0x1..0x4 with ack -> o_m0_data sequence 0x1..0x4; no data leaks to m1.
- Assert i_reset_n=0 mid-cycle -> o_s_cyc=0 and o_owner=00 the same clock. After release, m1 alone requesting is granted.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never acks -> o_m0_err is a single-clock pulse after 8 idle clocks and o_s_cyc drops. After m0 drops cyc, m1 gets the bus.
